// File: rtl/delay_tap_trainer.sv
`default_nettype none
// ============================================================================
// Module   : delay_tap_trainer
// Purpose  : Sweeps the 16 taps of an input delay element, scores each tap
//            with downstream compare results and parks the delay at the
//            centre of the longest contiguous passing window.
// Revision : 1.0 - initial release
// ============================================================================
module delay_tap_trainer #(
   parameter int SETTLE_CYCLES = 8,
   parameter int SAMPLE_CYCLES = 16
) (
   input  logic       CLK,
   input  logic       RSTN,
   input  logic       START,
   input  logic       SAMPLE_VLD,
   input  logic       SAMPLE_OK,
   output logic       DEL0,
   output logic       DEL1,
   output logic       DEL2,
   output logic       DEL3,
   output logic       BUSY,
   output logic       DONE,
   output logic       FAIL,
   output logic [3:0] WIN_LO,
   output logic [3:0] WIN_HI
);

   // One shared counter serves both the settle wait and the sample count.
   localparam int CNT_MAX = (SETTLE_CYCLES > SAMPLE_CYCLES) ? SETTLE_CYCLES : SAMPLE_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(SAMPLE_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SETTLE = 3'd1,
      SAMPLE = 3'd2,
      EVAL   = 3'd3,
      FINISH = 3'd4
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [3:0]       tap;
   logic             pass;
   logic [4:0]       run_len;
   logic [3:0]       run_start;
   logic [4:0]       best_len;
   logic [3:0]       best_lo;
   logic [3:0]       del;
   logic [4:0]       fin_len;
   logic [3:0]       fin_lo;

   assign DEL0 = del[0];
   assign DEL1 = del[1];
   assign DEL2 = del[2];
   assign DEL3 = del[3];

   // State register.
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next-state decode plus the final window choice (an open run at tap 15
   // competes with the best closed run; strict-greater keeps the earliest).
   always_comb begin
      state_nxt = state;
      fin_len   = best_len;
      fin_lo    = best_lo;
      if (run_len > best_len) begin
         fin_len = run_len;
         fin_lo  = run_start;
      end
      case (state)
         IDLE:    if (START) state_nxt = SETTLE;
         SETTLE:  if (cnt == SETTLE_LAST) state_nxt = SAMPLE;
         SAMPLE:  if (SAMPLE_VLD && (cnt == SAMPLE_LAST)) state_nxt = EVAL;
         EVAL:    state_nxt = (tap == 4'd15) ? FINISH : SETTLE;
         FINISH:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Datapath: tap sweep, per-tap scoring, run tracking and result outputs.
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         cnt       <= '0;
         tap       <= 4'd0;
         pass      <= 1'b0;
         run_len   <= 5'd0;
         run_start <= 4'd0;
         best_len  <= 5'd0;
         best_lo   <= 4'd0;
         del       <= 4'd0;
         BUSY      <= 1'b0;
         DONE      <= 1'b0;
         FAIL      <= 1'b0;
         WIN_LO    <= 4'd0;
         WIN_HI    <= 4'd0;
      end else begin
         case (state)
            IDLE: begin
               if (START) begin
                  cnt       <= '0;
                  tap       <= 4'd0;
                  pass      <= 1'b0;
                  run_len   <= 5'd0;
                  run_start <= 4'd0;
                  best_len  <= 5'd0;
                  best_lo   <= 4'd0;
                  del       <= 4'd0;
                  BUSY      <= 1'b1;
                  DONE      <= 1'b0;
                  FAIL      <= 1'b0;
               end
            end
            SETTLE: begin
               if (cnt == SETTLE_LAST) begin
                  cnt  <= '0;
                  pass <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            SAMPLE: begin
               if (SAMPLE_VLD) begin
                  if (!SAMPLE_OK) pass <= 1'b0;
                  if (cnt == SAMPLE_LAST) cnt <= '0;
                  else                    cnt <= cnt + 1'b1;
               end
            end
            EVAL: begin
               if (pass) begin
                  if (run_len == 5'd0) run_start <= tap;
                  run_len <= run_len + 5'd1;
               end else begin
                  if (run_len > best_len) begin
                     best_lo  <= run_start;
                     best_len <= run_len;
                  end
                  run_len <= 5'd0;
               end
               if (tap != 4'd15) begin
                  tap <= tap + 4'd1;
                  del <= tap + 4'd1;
               end
            end
            FINISH: begin
               // Window lengths are 1..16, so 4-bit modular arithmetic gives
               // the same in-range result as the 5-bit form.
               if (fin_len == 5'd0) begin
                  FAIL   <= 1'b1;
                  del    <= 4'd0;
                  WIN_LO <= 4'd0;
                  WIN_HI <= 4'd0;
               end else begin
                  WIN_LO <= fin_lo;
                  WIN_HI <= fin_lo + fin_len[3:0] - 4'd1;
                  del    <= fin_lo + ((fin_len[3:0] - 4'd1) >> 1);
               end
               BUSY <= 1'b0;
               DONE <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_delay_tap_trainer.sv
`default_nettype none
// ============================================================================
// Module   : tb_delay_tap_trainer
// Purpose  : Directed, table-driven bench for delay_tap_trainer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_delay_tap_trainer;

   logic       CLK = 1'b0;
   logic       RSTN;
   logic       START;
   logic       SAMPLE_VLD;
   logic       SAMPLE_OK;
   logic       DEL0, DEL1, DEL2, DEL3;
   logic       BUSY, DONE, FAIL;
   logic [3:0] WIN_LO, WIN_HI;
   logic [3:0] del;

   int n_chk  = 0;
   int n_fail = 0;

   assign del = {DEL3, DEL2, DEL1, DEL0};

   delay_tap_trainer #(.SETTLE_CYCLES(8), .SAMPLE_CYCLES(16)) dut (
      .CLK        (CLK),
      .RSTN       (RSTN),
      .START      (START),
      .SAMPLE_VLD (SAMPLE_VLD),
      .SAMPLE_OK  (SAMPLE_OK),
      .DEL0       (DEL0),
      .DEL1       (DEL1),
      .DEL2       (DEL2),
      .DEL3       (DEL3),
      .BUSY       (BUSY),
      .DONE       (DONE),
      .FAIL       (FAIL),
      .WIN_LO     (WIN_LO),
      .WIN_HI     (WIN_HI)
   );

   always #5 CLK = ~CLK;

   // One sweep scenario and its hand-computed outcome.
   typedef struct {
      logic [15:0] mask;         // taps whose compares pass
      bit          vld_toggle;   // SAMPLE_VLD high only on even cycles
      int          glitch;       // cycle index forced to OK=0 (-1 = none)
      bit          start_pulse;  // fire START while busy
      int          exp_cyc;      // cycle index where DONE first reads 1
      logic [3:0]  lo;
      logic [3:0]  hi;
      logic [3:0]  dl;
      logic        fl;
   } vec_t;

   vec_t vecs[9];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Cycle i is the cycle following the i-th edge after the accepting edge.
   task automatic run_sweep(input vec_t v, output int cyc, output int busy_cnt);
      START      = 1'b1;
      SAMPLE_VLD = 1'b0;
      SAMPLE_OK  = 1'b0;
      @(posedge CLK); #1;
      START = 1'b0;
      chk("start_busy", {31'd0, BUSY}, 32'd1);
      chk("start_done", {31'd0, DONE}, 32'd0);
      chk("start_del",  {28'd0, del},  32'd0);
      busy_cnt = 0;
      cyc      = -1;
      for (int i = 0; i < 1200; i++) begin
         SAMPLE_VLD = v.vld_toggle ? (i % 2 == 0) : 1'b1;
         SAMPLE_OK  = v.mask[del] && (i != v.glitch);
         START      = v.start_pulse && (i == 100 || i == 200 || i == 300);
         @(negedge CLK);
         if (DONE) begin
            cyc = i;
            break;
         end
         if (BUSY) busy_cnt++;
         @(posedge CLK); #1;
      end
      START      = 1'b0;
      SAMPLE_VLD = 1'b0;
      SAMPLE_OK  = 1'b0;
   endtask

   initial begin
      int cyc;
      int bc;

      // Default sweep: 16 taps * (8 + 16 + 1) + 1 = 401 cycles.
      // Toggled VLD with even-cycle valid: every tap starts on an even cycle,
      // its SAMPLE phase opens on a valid cycle and needs 31 cycles, so each
      // tap costs 40 cycles -> 16*40 + 1 = 641.
      vecs[0] = '{16'hFFFF, 1'b0,  -1, 1'b0, 401, 4'd0,  4'd15, 4'd7,  1'b0};
      vecs[1] = '{16'h07F0, 1'b0,  -1, 1'b1, 401, 4'd4,  4'd10, 4'd7,  1'b0};
      // Tap 10 starts at cycle 250; its 16th sample lands at cycle 273.
      vecs[2] = '{16'h07F0, 1'b0, 273, 1'b0, 401, 4'd4,  4'd9,  4'd6,  1'b0};
      vecs[3] = '{16'h0E0E, 1'b0,  -1, 1'b0, 401, 4'd1,  4'd3,  4'd2,  1'b0};
      vecs[4] = '{16'hF000, 1'b0,  -1, 1'b0, 401, 4'd12, 4'd15, 4'd13, 1'b0};
      vecs[5] = '{16'h0000, 1'b0,  -1, 1'b0, 401, 4'd0,  4'd0,  4'd0,  1'b1};
      vecs[6] = '{16'hFFFF, 1'b1,  -1, 1'b0, 641, 4'd0,  4'd15, 4'd7,  1'b0};
      vecs[7] = '{16'h0001, 1'b0,  -1, 1'b0, 401, 4'd0,  4'd0,  4'd0,  1'b0};
      vecs[8] = '{16'h8000, 1'b0,  -1, 1'b0, 401, 4'd15, 4'd15, 4'd15, 1'b0};

      RSTN = 1'b0; START = 1'b0; SAMPLE_VLD = 1'b0; SAMPLE_OK = 1'b0;
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      chk("rst_del",    {28'd0, del},    32'd0);
      chk("rst_busy",   {31'd0, BUSY},   32'd0);
      chk("rst_done",   {31'd0, DONE},   32'd0);
      chk("rst_fail",   {31'd0, FAIL},   32'd0);
      chk("rst_win_lo", {28'd0, WIN_LO}, 32'd0);
      chk("rst_win_hi", {28'd0, WIN_HI}, 32'd0);
      @(posedge CLK); #1;
      RSTN = 1'b1;
      repeat (2) @(posedge CLK);
      @(negedge CLK);

      // Back-to-back sweeps: each new START is driven in the DONE cycle.
      for (int n = 0; n < 9; n++) begin
         run_sweep(vecs[n], cyc, bc);
         chk($sformatf("v%0d_done_cycle", n), cyc, vecs[n].exp_cyc);
         chk($sformatf("v%0d_busy_len", n),   bc,  vecs[n].exp_cyc);
         chk($sformatf("v%0d_busy_end", n),   {31'd0, BUSY},   32'd0);
         chk($sformatf("v%0d_fail", n),       {31'd0, FAIL},   {31'd0, vecs[n].fl});
         chk($sformatf("v%0d_win_lo", n),     {28'd0, WIN_LO}, {28'd0, vecs[n].lo});
         chk($sformatf("v%0d_win_hi", n),     {28'd0, WIN_HI}, {28'd0, vecs[n].hi});
         chk($sformatf("v%0d_del", n),        {28'd0, del},    {28'd0, vecs[n].dl});
      end

      // Results hold in IDLE while nothing happens.
      repeat (5) @(negedge CLK);
      chk("hold_done",   {31'd0, DONE},   32'd1);
      chk("hold_win_lo", {28'd0, WIN_LO}, 32'd15);
      chk("hold_del",    {28'd0, del},    32'd15);

      // Asynchronous reset mid-sweep at tap 6 (tap 6 spans cycles 150..174).
      START = 1'b1;
      @(posedge CLK); #1;
      START = 1'b0;
      SAMPLE_VLD = 1'b1;
      SAMPLE_OK  = 1'b1;
      repeat (160) @(posedge CLK);
      #1;
      chk("mid_del_tap6", {28'd0, del},  32'd6);
      chk("mid_busy",     {31'd0, BUSY}, 32'd1);
      #2;
      RSTN = 1'b0;
      #1;
      chk("arst_del",    {28'd0, del},    32'd0);
      chk("arst_busy",   {31'd0, BUSY},   32'd0);
      chk("arst_done",   {31'd0, DONE},   32'd0);
      chk("arst_fail",   {31'd0, FAIL},   32'd0);
      chk("arst_win_lo", {28'd0, WIN_LO}, 32'd0);
      chk("arst_win_hi", {28'd0, WIN_HI}, 32'd0);
      @(posedge CLK); #1;
      RSTN = 1'b1;
      repeat (30) @(posedge CLK);
      @(negedge CLK);
      chk("post_rst_busy", {31'd0, BUSY}, 32'd0);
      chk("post_rst_done", {31'd0, DONE}, 32'd0);
      chk("post_rst_del",  {28'd0, del},  32'd0);

      // Recovery: a full sweep after the aborted one.
      run_sweep(vecs[0], cyc, bc);
      chk("rec_done_cycle", cyc, 401);
      chk("rec_win_hi", {28'd0, WIN_HI}, 32'd15);
      chk("rec_del",    {28'd0, del},    32'd7);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
